// File: rtl/trap_ctrl.sv
// Trap controller: detects ecall/ebreak/mret/external irq in ID, sequences the
// mepc/mcause/mstatus CSR writes, then issues a one-cycle PC redirect.
module trap_ctrl #(
    parameter logic [31:0] CAUSE_ECALL   = 32'h0000000B,
    parameter logic [31:0] CAUSE_EBREAK  = 32'h00000003,
    parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000000B
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        irq_i,
    input  logic        jump_enable_i,
    input  logic [31:0] jump_addr_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stallreq_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [XLEN-1:0]   INST_ECALL  = 32'h00000073;
    localparam logic [XLEN-1:0]   INST_EBREAK = 32'h00100073;
    localparam logic [XLEN-1:0]   INST_MRET   = 32'h30200073;
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MSTATUS = 3'd3,
        W_MRET    = 3'd4,
        JUMP      = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_status;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] w_epc;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_status;
    logic [XLEN-1:0] w_target;
    logic            w_irq;
    logic [XLEN-1:0] w_mtvec_base;

    // State and trap-context registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_status <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_next;
            r_epc    <= w_epc;
            r_cause  <= w_cause;
            r_status <= w_status;
            r_target <= w_target;
        end
    end

    assign w_irq        = irq_i & csr_mstatus_i[3];
    assign w_mtvec_base = csr_mtvec_i & ~XLEN'(3);

    // Next-state and output decode; outputs are forced low while in reset.
    always_comb begin
        w_next       = r_state;
        w_epc        = r_epc;
        w_cause      = r_cause;
        w_status     = r_status;
        w_target     = r_target;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        stallreq_o   = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;

        case (r_state)
            IDLE: begin
                if (inst_i == INST_ECALL) begin
                    stallreq_o = 1'b1;
                    w_epc      = inst_addr_i;
                    w_cause    = CAUSE_ECALL;
                    w_status   = csr_mstatus_i;
                    w_next     = W_MEPC;
                end else if (inst_i == INST_EBREAK) begin
                    stallreq_o = 1'b1;
                    w_epc      = inst_addr_i;
                    w_cause    = CAUSE_EBREAK;
                    w_status   = csr_mstatus_i;
                    w_next     = W_MEPC;
                end else if (inst_i == INST_MRET) begin
                    stallreq_o = 1'b1;
                    w_status   = csr_mstatus_i;
                    w_next     = W_MRET;
                end else if (w_irq) begin
                    // A redirecting EXE means the ID instruction is squashed;
                    // resume at the redirect target instead.
                    stallreq_o = 1'b1;
                    w_epc      = jump_enable_i ? jump_addr_i : inst_addr_i;
                    w_cause    = CAUSE_EXT_IRQ;
                    w_status   = csr_mstatus_i;
                    w_next     = W_MEPC;
                end
            end
            W_MEPC: begin
                stallreq_o  = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = r_epc;
                w_next      = W_MCAUSE;
            end
            W_MCAUSE: begin
                stallreq_o  = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = r_cause;
                w_next      = W_MSTATUS;
            end
            W_MSTATUS: begin
                stallreq_o  = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = {r_status[31:8], r_status[3], r_status[6:4], 1'b0, r_status[2:0]};
                w_target    = w_mtvec_base;
                w_next      = JUMP;
            end
            W_MRET: begin
                stallreq_o  = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = {r_status[31:8], 1'b1, r_status[6:4], r_status[7], r_status[2:0]};
                w_target    = csr_mepc_i;
                w_next      = JUMP;
            end
            JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = r_target;
                w_next       = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        if (!rst_i) begin
            csr_we_o     = 1'b0;
            csr_waddr_o  = '0;
            csr_wdata_o  = '0;
            stallreq_o   = 1'b0;
            int_assert_o = 1'b0;
            int_addr_o   = '0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, irq, mret, priority, masking and reset abort.
module tb_trap_ctrl;

    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] MRET   = 32'h30200073;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        irq_i;
    logic        jump_enable_i;
    logic [31:0] jump_addr_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        stallreq_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [78:0] exp_v;
    logic [78:0] obs;

    trap_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .irq_i         (irq_i),
        .jump_enable_i (jump_enable_i),
        .jump_addr_i   (jump_addr_i),
        .csr_mtvec_i   (csr_mtvec_i),
        .csr_mepc_i    (csr_mepc_i),
        .csr_mstatus_i (csr_mstatus_i),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .stallreq_o    (stallreq_o),
        .int_assert_o  (int_assert_o),
        .int_addr_o    (int_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed output bundle: {stall, we, waddr, wdata, int_assert, int_addr}.
    assign obs = {stallreq_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; inst_i = ECALL; inst_addr_i = 32'h10; irq_i = 1'b1;
        jump_enable_i = 1'b0; jump_addr_i = 32'h0; csr_mtvec_i = 32'h205;
        csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
        tick(); tick(); settle();
        exp_v = '0; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_outputs got %h exp %h", obs, exp_v); end
        inst_i = NOP; irq_i = 1'b0;
        rst_i = 1'b1; settle();
        n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_idle got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_ecall();
        tick();
        inst_i = ECALL; inst_addr_i = 32'h100; csr_mtvec_i = 32'h205; csr_mstatus_i = 32'h8; settle();
        exp_v = {1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecall_c0 got %h exp %h", obs, exp_v); end
        tick(); inst_i = MRET; settle();
        exp_v = {1'b1, 1'b1, 12'h341, 32'h100, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecall_mepc got %h exp %h", obs, exp_v); end
        tick(); inst_i = EBREAK; settle();
        exp_v = {1'b1, 1'b1, 12'h342, 32'hB, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecall_mcause got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b1, 1'b1, 12'h300, 32'h80, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecall_mstatus got %h exp %h", obs, exp_v); end
        tick(); inst_i = ECALL; csr_mstatus_i = 32'h80; settle();
        exp_v = {1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'h204}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecall_jump got %h exp %h", obs, exp_v); end
        tick(); inst_i = NOP; settle();
        exp_v = '0; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecall_after got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_irq();
        tick();
        inst_i = NOP; inst_addr_i = 32'h200; irq_i = 1'b1; csr_mstatus_i = 32'h8;
        jump_enable_i = 1'b1; jump_addr_i = 32'h400; csr_mtvec_i = 32'h300; settle();
        exp_v = {1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_c0 got %h exp %h", obs, exp_v); end
        tick(); irq_i = 1'b0; jump_enable_i = 1'b0; jump_addr_i = 32'h0; settle();
        exp_v = {1'b1, 1'b1, 12'h341, 32'h400, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_mepc got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b1, 1'b1, 12'h342, 32'h8000000B, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_mcause got %h exp %h", obs, exp_v); end
        tick(); tick(); settle();
        exp_v = {1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'h300}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_jump got %h exp %h", obs, exp_v); end
        // No EXE redirect: epc comes from the ID instruction address.
        tick();
        inst_addr_i = 32'h208; irq_i = 1'b1; csr_mstatus_i = 32'h8; settle();
        tick(); irq_i = 1'b0; settle();
        exp_v = {1'b1, 1'b1, 12'h341, 32'h208, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_noj_mepc got %h exp %h", obs, exp_v); end
        tick(); tick(); tick(); tick(); settle();
    endtask

    task automatic test_irq_masked();
        inst_i = NOP; irq_i = 1'b1; csr_mstatus_i = 32'h0; settle();
        for (int i = 0; i < 3; i++) begin
            exp_v = '0; n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL irq_masked_c%0d got %h exp %h", i, obs, exp_v); end
            tick();
        end
        irq_i = 1'b0;
    endtask

    task automatic test_mret();
        inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h400; settle();
        exp_v = {1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_c0 got %h exp %h", obs, exp_v); end
        tick(); inst_i = NOP; settle();
        exp_v = {1'b1, 1'b1, 12'h300, 32'h88, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_mstatus got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'h400}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_jump got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = '0; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL mret_after got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_ebreak();
        // ebreak outranks a pending enabled irq; other mstatus bits pass through.
        inst_i = EBREAK; inst_addr_i = 32'h180; irq_i = 1'b1; csr_mstatus_i = 32'h1888;
        csr_mtvec_i = 32'h1003; settle();
        tick(); inst_i = NOP; irq_i = 1'b0; settle();
        exp_v = {1'b1, 1'b1, 12'h341, 32'h180, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ebreak_mepc got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b1, 1'b1, 12'h342, 32'h3, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ebreak_mcause got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b1, 1'b1, 12'h300, 32'h1880, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ebreak_mstatus got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'h1000}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ebreak_jump got %h exp %h", obs, exp_v); end
        tick(); csr_mstatus_i = 32'h0; settle();
    endtask

    task automatic test_ecall_irq();
        inst_i = ECALL; inst_addr_i = 32'h300; irq_i = 1'b1; csr_mstatus_i = 32'h8;
        csr_mtvec_i = 32'h800; settle();
        tick(); inst_i = NOP; settle();
        exp_v = {1'b1, 1'b1, 12'h341, 32'h300, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecirq_mepc got %h exp %h", obs, exp_v); end
        tick(); settle();
        exp_v = {1'b1, 1'b1, 12'h342, 32'hB, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecirq_mcause got %h exp %h", obs, exp_v); end
        tick(); tick(); csr_mstatus_i = 32'h80; settle();
        exp_v = {1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'h800}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ecirq_jump got %h exp %h", obs, exp_v); end
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            exp_v = '0; n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL ecirq_masked_c%0d got %h exp %h", i, obs, exp_v); end
        end
        irq_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        inst_i = ECALL; inst_addr_i = 32'h500; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h900; settle();
        tick(); inst_i = NOP; settle();
        tick(); settle();
        exp_v = {1'b1, 1'b1, 12'h342, 32'hB, 1'b0, 32'h0}; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_mcause got %h exp %h", obs, exp_v); end
        rst_i = 1'b0;
        tick(); settle();
        exp_v = '0; n_vec++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_next got %h exp %h", obs, exp_v); end
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            n_vec++;
            if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_after_c%0d got %h exp %h", i, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_irq();
        test_irq_masked();
        test_mret();
        test_ebreak();
        test_ecall_irq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
